// File: rtl/lc3b_types.sv
// lc3b_types
//   Shared types for the LC-3b pipeline memory path. Holds the word and
//   write-mask types plus the line-buffer types and the FSM state encoding
//   used by the data-memory line responder.
//
//   Helpers:
//     get_word   - extract 16-bit word <off> from a 128-bit line
//     merge_word - apply a 2-bit byte mask to a word (bit 1 = high byte)
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;

  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_tag;
  typedef logic [2:0]   lc3b_line_offset;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } responder_state_t;

  // Word i lives in line[16i+15:16i]; {off, 4'b0} is 16*off.
  function automatic lc3b_word get_word(input lc3b_line line,
                                        input lc3b_line_offset off);
    return line[{off, 4'b0000} +: 16];
  endfunction

  function automatic lc3b_word merge_word(input lc3b_word      old_word,
                                          input lc3b_word      wdata,
                                          input lc3b_mem_wmask be);
    lc3b_word w_out;
    w_out = old_word;
    if (be[0]) w_out[7:0]  = wdata[7:0];
    if (be[1]) w_out[15:8] = wdata[15:8];
    return w_out;
  endfunction

endpackage

// File: rtl/responder_control.sv
// responder_control
//   Control FSM for the data-memory line responder. Decides hit/miss in
//   IDLE, sequences the optional write-back and the line fetch on the pmem
//   side, and decodes every strobe the datapath needs.
//
//   Ports:
//     clk, reset          - clock, synchronous active-high reset
//     mem_read, mem_write - requester handshake (held until mem_resp)
//     hit                 - line valid and tag matches the request
//     line_dirty          - line valid and modified
//     pmem_resp           - physical-memory completion
//     mem_resp            - completion pulse to the requester
//     rdata_en            - gate read data onto mem_rdata
//     pmem_read           - line fetch request (registered)
//     pmem_write          - line write-back request (registered)
//     load_line           - install pmem_rdata and the request tag
//     write_word          - merge write data into the selected word
//     clear_dirty         - write-back accepted
module responder_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic reset,
  input  logic mem_read,
  input  logic mem_write,
  input  logic hit,
  input  logic line_dirty,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic rdata_en,
  output logic pmem_read,
  output logic pmem_write,
  output logic load_line,
  output logic write_word,
  output logic clear_dirty
);

  responder_state_t r_state;
  logic             r_pmem_read;
  logic             r_pmem_write;
  logic             w_req;

  assign w_req = mem_read | mem_write;

  // pmem strobes are registered alongside the state update so they are
  // pure state decodes: no combinational path from pmem_resp, and the
  // two can never be high together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !hit) begin
            if (line_dirty) begin
              r_state      <= WRITEBACK;
              r_pmem_write <= 1'b1;
            end else begin
              r_state     <= FETCH;
              r_pmem_read <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            r_state      <= FETCH;
            r_pmem_write <= 1'b0;
            r_pmem_read  <= 1'b1;
          end
        end
        FETCH: begin
          if (pmem_resp) begin
            r_state     <= IDLE;
            r_pmem_read <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read  = r_pmem_read;
  assign pmem_write = r_pmem_write;

  // Hits answer in the same cycle. A read+write collision is treated as a
  // write, so read data is only enabled for a pure read.
  always_comb begin
    mem_resp    = 1'b0;
    rdata_en    = 1'b0;
    write_word  = 1'b0;
    load_line   = 1'b0;
    clear_dirty = 1'b0;
    case (r_state)
      IDLE: begin
        mem_resp   = w_req & hit;
        rdata_en   = w_req & hit & mem_read & ~mem_write;
        write_word = w_req & hit & mem_write;
      end
      WRITEBACK: clear_dirty = pmem_resp;
      FETCH:     load_line   = pmem_resp;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_line_responder.sv
// dmem_line_responder
//   Memory-side responder for the pipeline's data-memory port. Serves
//   word reads/writes from a single 128-bit write-back line buffer and
//   fetches/evicts whole lines over the 128-bit pmem interface.
//
//   Ports:
//     clk, reset       - clock, synchronous active-high reset
//     mem_read/write   - word request, held until mem_resp
//     mem_address      - byte address (bit 0 ignored)
//     mem_wdata        - write data
//     mem_byte_enable  - write mask, bit 1 = high byte
//     mem_rdata        - read data, valid with mem_resp
//     mem_resp         - single-cycle completion
//     pmem_read/write  - line fetch / write-back request, held until pmem_resp
//     pmem_address     - line-aligned address
//     pmem_wdata       - buffered line for write-back
//     pmem_rdata       - fetched line, valid with pmem_resp
//     pmem_resp        - physical-memory completion
module dmem_line_responder
  import lc3b_types::*;
#(
  parameter int unsigned S_OFFSET = 4
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [15:0]   mem_address,
  input  logic [15:0]   mem_wdata,
  input  logic [1:0]    mem_byte_enable,
  output logic [15:0]   mem_rdata,
  output logic          mem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [15:0]   pmem_address,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp
);

  lc3b_line        r_line;
  lc3b_line_tag    r_tag;
  logic            r_valid;
  logic            r_dirty;

  lc3b_line_tag    w_req_tag;
  lc3b_line_offset w_offset;
  logic            w_hit;
  logic            w_line_dirty;
  logic            w_load_line;
  logic            w_write_word;
  logic            w_clear_dirty;
  logic            w_rdata_en;
  lc3b_word        w_sel_word;
  lc3b_word        w_merged_word;
  lc3b_line        w_written_line;
  logic            w_unused;

  assign w_req_tag    = mem_address[15:S_OFFSET];
  assign w_offset     = mem_address[S_OFFSET-1:1];
  assign w_unused     = mem_address[0];

  assign w_hit        = r_valid && (r_tag == w_req_tag);
  assign w_line_dirty = r_valid && r_dirty;

  responder_control u_control (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .hit         (w_hit),
    .line_dirty  (w_line_dirty),
    .pmem_resp   (pmem_resp),
    .mem_resp    (mem_resp),
    .rdata_en    (w_rdata_en),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .load_line   (w_load_line),
    .write_word  (w_write_word),
    .clear_dirty (w_clear_dirty)
  );

  assign w_sel_word    = get_word(r_line, w_offset);
  assign w_merged_word = merge_word(w_sel_word, mem_wdata, mem_byte_enable);

  always_comb begin
    w_written_line = r_line;
    w_written_line[{w_offset, 4'b0000} +: 16] = w_merged_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_line  <= '0;
      r_tag   <= '0;
      r_valid <= 1'b0;
      r_dirty <= 1'b0;
    end else if (w_load_line) begin
      r_line  <= pmem_rdata;
      r_tag   <= w_req_tag;
      r_valid <= 1'b1;
      r_dirty <= 1'b0;
    end else begin
      if (w_clear_dirty) r_dirty <= 1'b0;
      // An all-zero byte mask still counts as a write and marks the line dirty.
      if (w_write_word) begin
        r_line  <= w_written_line;
        r_dirty <= 1'b1;
      end
    end
  end

  assign mem_rdata  = w_rdata_en ? w_sel_word : '0;
  assign pmem_wdata = r_line;

  // Write-back targets the resident line; fetch targets the live request.
  always_comb begin
    pmem_address = '0;
    if (pmem_write)     pmem_address = {r_tag, {S_OFFSET{1'b0}}};
    else if (pmem_read) pmem_address = {w_req_tag, {S_OFFSET{1'b0}}};
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
module tb_dmem_line_responder;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_read, mem_write;
  logic [15:0]   mem_address, mem_wdata;
  logic [1:0]    mem_byte_enable;
  logic [15:0]   mem_rdata;
  logic          mem_resp;
  logic          pmem_read, pmem_write;
  logic [15:0]   pmem_address;
  logic [127:0]  pmem_wdata, pmem_rdata;
  logic          pmem_resp;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_line_responder #(.S_OFFSET(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // One request with a behavioural pmem: the write-back answers in the
  // cycle its wb_lat-th high cycle is seen, the fetch likewise with fe_lat.
  // Expected read data is queued at issue and popped at mem_resp.
  task automatic run_req(input string tag, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wd,
                         input logic [1:0] be, input logic [127:0] fline,
                         input int wb_lat, input int fe_lat,
                         input logic [15:0] exp_wbaddr, input logic [127:0] exp_wbdata,
                         input logic [15:0] exp_rdata, input int exp_cyc);
    int c, wcnt, rcnt, first_rd;
    logic done;
    logic [15:0] exp_word;
    next_cycle();
    mem_read = rd; mem_write = wr; mem_address = addr;
    mem_wdata = wd; mem_byte_enable = be; pmem_rdata = fline; pmem_resp = 1'b0;
    exp_q.push_back((rd && !wr) ? exp_rdata : 16'h0000);
    c = 0; wcnt = 0; rcnt = 0; first_rd = -1; done = 1'b0;
    while (!done && c < 64) begin
      @(negedge clk);
      chk({tag, " pmem_excl"}, {127'b0, pmem_read & pmem_write}, 128'd0);
      pmem_resp = 1'b0;
      if (pmem_write) begin
        wcnt++;
        if (wcnt == 1) begin
          chk({tag, " wb_addr"}, {112'b0, pmem_address}, {112'b0, exp_wbaddr});
          chk({tag, " wb_data"}, pmem_wdata, exp_wbdata);
        end
        if (wcnt == wb_lat) pmem_resp = 1'b1;
      end
      if (pmem_read) begin
        rcnt++;
        if (rcnt == 1) begin
          first_rd = c;
          chk({tag, " fetch_addr"}, {112'b0, pmem_address}, {112'b0, addr[15:4], 4'h0});
        end
        if (rcnt == fe_lat) pmem_resp = 1'b1;
      end
      if (mem_resp) begin
        done = 1'b1;
        chk_int({tag, " resp_cycle"}, c, exp_cyc);
        exp_word = exp_q.pop_front();
        chk({tag, " rdata"}, {112'b0, mem_rdata}, {112'b0, exp_word});
      end else begin
        next_cycle();
        c++;
      end
    end
    chk({tag, " resp_seen"}, {127'b0, done}, 128'd1);
    chk_int({tag, " wb_cycles"}, wcnt, wb_lat);
    chk_int({tag, " fetch_cycles"}, rcnt, fe_lat);
    chk_int({tag, " fetch_start"}, first_rd, (fe_lat > 0) ? wb_lat + 1 : -1);
    next_cycle();
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
  endtask

  localparam logic [127:0] L1 = 128'h7777_6666_5555_4444_BEEF_2222_1111_0000;
  localparam logic [127:0] L1W = 128'h7777_6666_5555_4444_BE34_2222_1111_0000;
  localparam logic [127:0] L2 = 128'h0F0F_E0E0_D0D0_C0C0_B0B0_A0A0_9090_8080;
  localparam logic [127:0] L3 = 128'h3333_4444_5555_6666_7777_8888_9999_AAAA;
  localparam logic [127:0] L4 = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
  localparam logic [127:0] L5 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] L6 = {8{16'h1357}};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
    mem_wdata = '0; mem_byte_enable = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst mem_resp",     {127'b0, mem_resp},   128'd0);
    chk("rst mem_rdata",    {112'b0, mem_rdata},  128'd0);
    chk("rst pmem_read",    {127'b0, pmem_read},  128'd0);
    chk("rst pmem_write",   {127'b0, pmem_write}, 128'd0);
    chk("rst pmem_wdata",   pmem_wdata,           128'd0);
    chk("rst pmem_address", {112'b0, pmem_address}, 128'd0);
    next_cycle();
    reset = 1'b0;

    // Cold read, then same-cycle hit.
    run_req("cold_rd", 1, 0, 16'h3006, 0, 2'b00, L1, 0, 3, 0, 0, 16'hBEEF, 4);
    run_req("hit_rd",  1, 0, 16'h3006, 0, 2'b00, '0, 0, 0, 0, 0, 16'hBEEF, 0);
    // Low-byte write hit, readback.
    run_req("bwr_lo",  0, 1, 16'h3006, 16'h1234, 2'b01, '0, 0, 0, 0, 0, 0, 0);
    run_req("rd_lo",   1, 0, 16'h3006, 0, 2'b00, '0, 0, 0, 0, 0, 16'hBE34, 0);
    // Dirty eviction.
    run_req("evict",   1, 0, 16'h4000, 0, 2'b00, L2, 2, 2, 16'h3000, L1W, 16'h8080, 5);
    run_req("rd_w7",   1, 0, 16'h400E, 0, 2'b00, '0, 0, 0, 0, 0, 16'h0F0F, 0);
    // Zero byte mask: responds, leaves data, still dirties the line.
    run_req("wr_be0",  0, 1, 16'h4004, 16'hFFFF, 2'b00, '0, 0, 0, 0, 0, 0, 0);
    run_req("rd_be0",  1, 0, 16'h4004, 0, 2'b00, '0, 0, 0, 0, 0, 16'hA0A0, 0);
    run_req("evict2",  1, 0, 16'h5000, 0, 2'b00, L3, 1, 1, 16'h4000, L2, 16'hAAAA, 3);
    // Clean eviction.
    run_req("clean",   1, 0, 16'h6002, 0, 2'b00, L4, 0, 1, 0, 0, 16'h89AB, 2);

    // pmem_resp in IDLE is ignored.
    next_cycle();
    pmem_rdata = '1; pmem_resp = 1'b1;
    @(negedge clk);
    chk("idle_resp pmem_read", {127'b0, pmem_read}, 128'd0);
    next_cycle();
    pmem_resp = 1'b0;
    run_req("idle_resp_rd", 1, 0, 16'h6002, 0, 2'b00, L4, 0, 0, 0, 0, 16'h89AB, 0);

    // Withdrawn request during FETCH.
    next_cycle();
    mem_read = 1'b1; mem_address = 16'h7000; pmem_rdata = L5;
    @(negedge clk);
    chk("wd c0 mem_resp", {127'b0, mem_resp}, 128'd0);
    next_cycle();
    @(negedge clk);
    chk("wd c1 pmem_read",  {127'b0, pmem_read},  128'd1);
    chk("wd c1 pmem_write", {127'b0, pmem_write}, 128'd0);
    chk("wd c1 addr", {112'b0, pmem_address}, {112'b0, 16'h7000});
    next_cycle();
    mem_read = 1'b0;
    @(negedge clk);
    chk("wd c2 pmem_read", {127'b0, pmem_read}, 128'd1);
    chk("wd c2 mem_resp",  {127'b0, mem_resp},  128'd0);
    pmem_resp = 1'b1;
    next_cycle();
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("wd c3 pmem_read", {127'b0, pmem_read}, 128'd0);
    chk("wd c3 mem_resp",  {127'b0, mem_resp},  128'd0);
    run_req("wd_hit",  1, 0, 16'h700A, 0, 2'b00, '0, 0, 0, 0, 0, 16'h2222, 0);

    // High-byte write, then read+write collision treated as write.
    run_req("bwr_hi",  0, 1, 16'h7008, 16'h5A77, 2'b10, '0, 0, 0, 0, 0, 0, 0);
    run_req("rd_hi",   1, 0, 16'h7008, 0, 2'b00, '0, 0, 0, 0, 0, 16'h5A33, 0);
    run_req("rw_both", 1, 1, 16'h700A, 16'hCAFE, 2'b11, '0, 0, 0, 0, 0, 0, 0);
    run_req("rd_both", 1, 0, 16'h700A, 0, 2'b00, '0, 0, 0, 0, 0, 16'hCAFE, 0);

    // Reset during WRITEBACK.
    next_cycle();
    mem_read = 1'b1; mem_address = 16'h8000;
    next_cycle();
    @(negedge clk);
    chk("rwb pmem_write", {127'b0, pmem_write}, 128'd1);
    chk("rwb addr", {112'b0, pmem_address}, {112'b0, 16'h7000});
    next_cycle();
    reset = 1'b1; mem_read = 1'b0;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rwb after pmem_write", {127'b0, pmem_write}, 128'd0);
    chk("rwb after pmem_read",  {127'b0, pmem_read},  128'd0);
    chk("rwb after mem_resp",   {127'b0, mem_resp},   128'd0);
    chk("rwb after wdata",      pmem_wdata,           128'd0);
    run_req("post_rst", 1, 0, 16'h700A, 0, 2'b00, L6, 0, 2, 0, 0, 16'h1357, 3);

    chk_int("scoreboard empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
